// File: rtl/msk_symbol_timing_recovery.sv
// msk_symbol_timing_recovery
// Symbol timing recovery for a 2-sample/symbol I/Q stream. A linear
// interpolator at fractional offset mu produces alternating on-time (SYM)
// and mid-symbol (MID) interpolants. A Gardner TED evaluates each SYM
// interpolant, and a PI loop filter steers mu. When mu wraps above one
// sample, the next input sample is skipped. When mu wraps below zero, one
// input cycle is stalled and an extra interpolant is stuffed.
// The interpolant and the loop update are computed in the cycle in which the
// sample is accepted, and are registered on that same edge. As a result, a
// new mu always applies from the next interpolant onward.
module msk_symbol_timing_recovery #(
  parameter logic [15:0] MU_INIT  = 16'd0,
  parameter int          LOOP_EN  = 1,
  parameter int          E_SHIFT  = 14,
  parameter int          KP_SHIFT = 3,
  parameter int          KI_SHIFT = 9,
  parameter int          LOCK_THR = 512,
  parameter int          LOCK_CNT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] i_in,
  input  logic signed [15:0] q_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [15:0] sym_i,
  output logic signed [15:0] sym_q,
  output logic               sym_valid,
  output logic        [15:0] ted_err,
  output logic        [15:0] mu_out,
  output logic               locked
);

  localparam int LCW = $clog2(LOCK_CNT + 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STUFF = 1'b1
  } state_t;

  // ---------------------------------------------------------------- helpers
  function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
    logic signed [15:0] r;
    if (v > 19'sd32767) begin
      r = 16'sh7FFF;
    end else if (v < -19'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  function automatic logic signed [17:0] sat18(input logic signed [33:0] v);
    logic signed [17:0] r;
    if (v > 34'sd131071) begin
      r = 18'sh1FFFF;
    end else if (v < -34'sd131072) begin
      r = 18'sh20000;
    end else begin
      r = v[17:0];
    end
    return r;
  endfunction

  function automatic logic signed [23:0] sat24(input logic signed [24:0] v);
    logic signed [23:0] r;
    if (v > 25'sd8388607) begin
      r = 24'sh7FFFFF;
    end else if (v < -25'sd8388608) begin
      r = 24'sh800000;
    end else begin
      r = v[23:0];
    end
    return r;
  endfunction

  // Clamp the loop correction so that one update can wrap mu at most once.
  function automatic logic signed [17:0] clamp_ctrl(input logic signed [24:0] v);
    logic signed [17:0] r;
    if (v > 25'sd16383) begin
      r = 18'sd16383;
    end else if (v < -25'sd16383) begin
      r = -18'sd16383;
    end else begin
      r = v[17:0];
    end
    return r;
  endfunction

  // y = xp + floor((xc - xp) * mu / 2^15), saturated to 16 bits
  function automatic logic signed [15:0] interp(input logic signed [15:0] xp,
                                                input logic signed [15:0] xc,
                                                input logic        [15:0] mu);
    logic signed [16:0] d;
    logic signed [32:0] p;
    logic signed [32:0] ps;
    logic signed [18:0] y;
    d  = 17'(xc) - 17'(xp);
    p  = 33'(d) * 33'($signed({1'b0, mu[14:0]}));
    ps = p >>> 15;
    y  = 19'(xp) + 19'($signed(ps[17:0]));
    return sat16(y);
  endfunction

  // Gardner error: mid * (sym_prev - sym), summed over I and Q
  function automatic logic signed [33:0] gardner(input logic signed [15:0] mi,
                                                 input logic signed [15:0] spi,
                                                 input logic signed [15:0] si,
                                                 input logic signed [15:0] mq,
                                                 input logic signed [15:0] spq,
                                                 input logic signed [15:0] sq);
    logic signed [16:0] di;
    logic signed [16:0] dq;
    logic signed [32:0] pi;
    logic signed [32:0] pq;
    di = 17'(spi) - 17'(si);
    dq = 17'(spq) - 17'(sq);
    pi = 33'(mi) * 33'(di);
    pq = 33'(mq) * 33'(dq);
    return 34'(pi) + 34'(pq);
  endfunction

  // -------------------------------------------------------------- registers
  state_t             r_state;
  state_t             w_state_next;
  logic               r_in_ready;
  logic signed [15:0] r_xl_i, r_xl_q;       // last accepted sample
  logic signed [15:0] r_xp_i, r_xp_q;       // sample before that
  logic               r_have_prev;
  logic               r_skip;
  logic               r_phase_mid;          // 0: next interpolant is SYM
  logic signed [15:0] r_sym_i, r_sym_q;
  logic               r_sym_valid;
  logic signed [15:0] r_sp_i, r_sp_q;       // previous SYM interpolant
  logic signed [15:0] r_mid_i, r_mid_q;     // latest MID interpolant
  logic        [1:0]  r_sym_cnt;
  logic               r_have_mid;
  logic        [15:0] r_ted_err;
  logic signed [23:0] r_integ;
  logic        [15:0] r_mu;
  logic    [LCW-1:0]  r_lock_cnt;
  logic               r_locked;

  // ------------------------------------------------------------------ wires
  logic               w_acc;
  logic               w_stuff;
  logic signed [15:0] w_xp_i, w_xp_q, w_xc_i, w_xc_q;
  logic signed [15:0] w_y_i, w_y_q;
  logic               w_interp_go;
  logic               w_ted_go;
  logic               w_upd;
  logic signed [33:0] w_e;
  logic signed [17:0] w_es;
  logic        [17:0] w_es_abs;
  logic signed [17:0] w_kp, w_ki;
  logic signed [23:0] w_integ_next;
  logic signed [17:0] w_ctrl;
  logic signed [17:0] w_mu_sum;
  logic               w_wrap_hi, w_wrap_lo;
  logic        [15:0] w_mu_next;
  logic    [LCW-1:0]  w_lock_cnt_inc;

  assign w_acc   = in_valid & r_in_ready;
  assign w_stuff = (r_state == ST_STUFF);

  // A stuffed interpolant reuses the stored sample pair; otherwise the pair
  // is (last accepted sample, sample being accepted now).
  assign w_xp_i = w_stuff ? r_xp_i : r_xl_i;
  assign w_xp_q = w_stuff ? r_xp_q : r_xl_q;
  assign w_xc_i = w_stuff ? r_xl_i : i_in;
  assign w_xc_q = w_stuff ? r_xl_q : q_in;

  assign w_y_i = interp(w_xp_i, w_xc_i, r_mu);
  assign w_y_q = interp(w_xp_q, w_xc_q, r_mu);

  assign w_interp_go = w_stuff | (w_acc & r_have_prev & ~r_skip);
  // The error window needs two earlier SYM points, so the first two SYM
  // strobes after reset never update the loop.
  assign w_ted_go    = w_interp_go & ~r_phase_mid & (r_sym_cnt == 2'd2) & r_have_mid;
  assign w_upd       = w_ted_go & (LOOP_EN != 0);

  // TED, PI loop filter and mu wrap detection
  always_comb begin
    w_e            = gardner(r_mid_i, r_sp_i, w_y_i, r_mid_q, r_sp_q, w_y_q);
    w_es           = sat18(w_e >>> E_SHIFT);
    w_es_abs       = w_es[17] ? 18'(-w_es) : 18'(w_es);
    w_kp           = w_es >>> KP_SHIFT;
    w_ki           = w_es >>> KI_SHIFT;
    w_integ_next   = sat24(25'(r_integ) + 25'(w_ki));
    w_ctrl         = clamp_ctrl(25'(w_kp) + 25'(w_integ_next));
    w_mu_sum       = $signed({2'b00, r_mu}) + w_ctrl;
    w_wrap_hi      = (w_mu_sum > 18'sd32767);
    w_wrap_lo      = (w_mu_sum < 18'sd0);
    w_mu_next      = w_mu_sum[15:0];
    w_lock_cnt_inc = r_lock_cnt;
    if (w_wrap_hi) begin
      w_mu_next = 16'(w_mu_sum - 18'sd32768);
    end else if (w_wrap_lo) begin
      w_mu_next = 16'(w_mu_sum + 18'sd32768);
    end else begin
      w_mu_next = w_mu_sum[15:0];
    end
    if (r_lock_cnt == LCW'(LOCK_CNT)) begin
      w_lock_cnt_inc = r_lock_cnt;
    end else begin
      w_lock_cnt_inc = r_lock_cnt + LCW'(1);
    end
  end

  // Next-state logic: a negative mu wrap inserts one STUFF cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_upd & w_wrap_lo) begin
          w_state_next = ST_STUFF;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_STUFF: begin
        if (w_upd & w_wrap_lo) begin
          w_state_next = ST_STUFF;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  // State register and the registered ready, which is low during STUFF
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next == ST_RUN);
    end
  end

  // Sample history, interpolant outputs, TED history, loop and lock state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xl_i      <= 16'sd0;
      r_xl_q      <= 16'sd0;
      r_xp_i      <= 16'sd0;
      r_xp_q      <= 16'sd0;
      r_have_prev <= 1'b0;
      r_skip      <= 1'b0;
      r_phase_mid <= 1'b0;
      r_sym_i     <= 16'sd0;
      r_sym_q     <= 16'sd0;
      r_sym_valid <= 1'b0;
      r_sp_i      <= 16'sd0;
      r_sp_q      <= 16'sd0;
      r_mid_i     <= 16'sd0;
      r_mid_q     <= 16'sd0;
      r_sym_cnt   <= 2'd0;
      r_have_mid  <= 1'b0;
      r_ted_err   <= 16'd0;
      r_integ     <= 24'sd0;
      r_mu        <= MU_INIT;
      r_lock_cnt  <= '0;
      r_locked    <= 1'b0;
    end else begin
      r_sym_valid <= 1'b0;
      if (w_acc) begin
        r_xp_i      <= r_xl_i;
        r_xp_q      <= r_xl_q;
        r_xl_i      <= i_in;
        r_xl_q      <= q_in;
        r_have_prev <= 1'b1;
        if (r_skip) begin
          r_skip <= 1'b0;
        end
      end
      if (w_interp_go) begin
        r_phase_mid <= ~r_phase_mid;
        if (!r_phase_mid) begin
          r_sym_i     <= w_y_i;
          r_sym_q     <= w_y_q;
          r_sym_valid <= 1'b1;
          r_sp_i      <= w_y_i;
          r_sp_q      <= w_y_q;
          if (r_sym_cnt != 2'd2) begin
            r_sym_cnt <= r_sym_cnt + 2'd1;
          end
        end else begin
          r_mid_i    <= w_y_i;
          r_mid_q    <= w_y_q;
          r_have_mid <= 1'b1;
        end
      end
      if (w_ted_go) begin
        r_ted_err <= w_es[17:2];
        if (w_es_abs < 18'(LOCK_THR)) begin
          r_lock_cnt <= w_lock_cnt_inc;
          r_locked   <= (w_lock_cnt_inc == LCW'(LOCK_CNT));
        end else begin
          r_lock_cnt <= '0;
          r_locked   <= 1'b0;
        end
      end
      if (w_upd) begin
        r_integ <= w_integ_next;
        r_mu    <= w_mu_next;
        if (w_wrap_hi) begin
          r_skip <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign sym_i     = r_sym_i;
  assign sym_q     = r_sym_q;
  assign sym_valid = r_sym_valid;
  assign ted_err   = r_ted_err;
  assign mu_out    = r_mu;
  assign locked    = r_locked;

endmodule

// File: tb/tb_msk_symbol_timing_recovery.sv
// Directed bench for msk_symbol_timing_recovery.
// DUT A is open loop with mu = 0.5 (interpolation arithmetic).
// DUT B is closed loop with mu starting at 0 and a strong proportional path,
// so that a short hand-computed sequence drives the TED, a stuff, a skip and
// lock.
module tb_msk_symbol_timing_recovery;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic signed [15:0] x_i, x_q;
  logic               va, vb;

  logic               a_rdy, a_sv, a_lk;
  logic signed [15:0] a_si, a_sq;
  logic        [15:0] a_te, a_mu;
  logic               b_rdy, b_sv, b_lk;
  logic signed [15:0] b_si, b_sq;
  logic        [15:0] b_te, b_mu;

  msk_symbol_timing_recovery #(
    .MU_INIT(16'd16384), .LOOP_EN(0)
  ) u_dut_a (
    .clk(clk), .reset(reset), .i_in(x_i), .q_in(x_q), .in_valid(va),
    .in_ready(a_rdy), .sym_i(a_si), .sym_q(a_sq), .sym_valid(a_sv),
    .ted_err(a_te), .mu_out(a_mu), .locked(a_lk)
  );

  msk_symbol_timing_recovery #(
    .MU_INIT(16'd0), .LOOP_EN(1), .E_SHIFT(14), .KP_SHIFT(0), .KI_SHIFT(20),
    .LOCK_THR(512), .LOCK_CNT(2)
  ) u_dut_b (
    .clk(clk), .reset(reset), .i_in(x_i), .q_in(x_q), .in_valid(vb),
    .in_ready(b_rdy), .sym_i(b_si), .sym_q(b_sq), .sym_valid(b_sv),
    .ted_err(b_te), .mu_out(b_mu), .locked(b_lk)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one sample to DUT A (to_b=0) or DUT B (to_b=1) and hold it until
  // it is accepted. Returns #1 after the accepting edge.
  task automatic push(input bit to_b, input logic signed [15:0] xi,
                      input logic signed [15:0] xq);
    @(negedge clk);
    x_i = xi;
    x_q = xq;
    if (to_b) vb = 1'b1; else va = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (!(to_b ? b_rdy : a_rdy)) @(negedge clk);
    end
    chk("accept_wait", to_b ? b_rdy : a_rdy, 32'sd1);
    @(posedge clk);
    #1;
    va = 1'b0;
    vb = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    va = 1'b0;
    vb = 1'b0;
    x_i = 16'sd0;
    x_q = 16'sd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_sym_valid", a_sv, 32'sd0);
    chk("rst_a_sym_i", a_si, 32'sd0);
    chk("rst_a_ready", a_rdy, 32'sd1);
    chk("rst_a_mu", a_mu, 32'sd16384);
    chk("rst_b_mu", b_mu, 32'sd0);
    chk("rst_b_ted", b_te, 32'sd0);
    chk("rst_b_locked", b_lk, 32'sd0);
    reset = 1'b0;

    // ---- DUT A: ramp at mu = 0.5
    push(1'b0, 16'sd0, 16'sd0);
    chk("a_first_load_no_sym", a_sv, 32'sd0);
    push(1'b0, 16'sd100, -16'sd100);
    chk("a_sym1_valid", a_sv, 32'sd1);
    chk("a_sym1_i", a_si, 32'sd50);
    chk("a_sym1_q", a_sq, -32'sd50);
    @(posedge clk);
    #1;
    chk("a_strobe_one_cycle", a_sv, 32'sd0);
    push(1'b0, 16'sd200, -16'sd200);
    chk("a_mid_no_sym", a_sv, 32'sd0);
    chk("a_mid_sym_held", a_si, 32'sd50);
    push(1'b0, 16'sd300, -16'sd300);
    chk("a_sym2_i", a_si, 32'sd250);
    chk("a_sym2_q", a_sq, -32'sd250);
    push(1'b0, 16'sd400, -16'sd400);
    push(1'b0, 16'sd500, -16'sd500);
    chk("a_sym3_valid", a_sv, 32'sd1);
    chk("a_sym3_i", a_si, 32'sd450);
    // ---- DUT A: full-scale boundaries
    push(1'b0, 16'sd32767, 16'sd0);
    push(1'b0, -16'sd32768, 16'sd0);
    chk("a_floor_valid", a_sv, 32'sd1);
    chk("a_floor_i", a_si, -32'sd1);
    push(1'b0, 16'sd32767, 16'sd0);
    push(1'b0, 16'sd32767, 16'sd0);
    chk("a_max_i", a_si, 32'sd32767);
    chk("a_open_loop_mu", a_mu, 32'sd16384);
    chk("a_ready_tied", a_rdy, 32'sd1);

    // ---- DUT B: with mu = 0 each interpolant equals the older sample
    push(1'b1, 16'sd0, 16'sd0);
    push(1'b1, 16'sd0, 16'sd0);
    chk("b_sym1_i", b_si, 32'sd0);
    push(1'b1, 16'sd1000, 16'sd0);
    push(1'b1, 16'sd16384, 16'sd0);
    chk("b_sym2_i", b_si, 32'sd1000);
    chk("b_sym2_no_ted", b_te, 32'sd0);
    chk("b_sym2_mu", b_mu, 32'sd0);
    push(1'b1, 16'sd1100, 16'sd0);
    // e_s = 16384*(1000-1100)>>14 = -100, ctrl = -101: mu wraps below zero
    push(1'b1, 16'sd4376, 16'sd0);
    chk("b_sym3_i", b_si, 32'sd1100);
    chk("b_sym3_valid", b_sv, 32'sd1);
    chk("b_ted1", b_te, 32'sd65511);
    chk("b_mu_stuff", b_mu, 32'sd32667);
    chk("b_stuff_ready_low", b_rdy, 32'sd0);
    @(posedge clk);
    #1;
    chk("b_stuff_no_sym", b_sv, 32'sd0);
    chk("b_stuff_ready_back", b_rdy, 32'sd1);
    // Stuffed MID = 4365; e_s = 4365*(1100-4376)>>14 = -873
    push(1'b1, 16'sd4376, 16'sd0);
    chk("b_sym4_i", b_si, 32'sd4376);
    chk("b_ted2", b_te, 32'sd65317);
    chk("b_mu2", b_mu, 32'sd31792);
    chk("b_unlock_big_err", b_lk, 32'sd0);
    push(1'b1, 16'sd4376, 16'sd0);
    // SYM = -27416, e_s = 8491, ctrl = 8489: mu wraps above one, skip next
    push(1'b1, -16'sd28392, 16'sd0);
    chk("b_sym5_i", b_si, -32'sd27416);
    chk("b_ted3", b_te, 32'sd2122);
    chk("b_mu_skip", b_mu, 32'sd7513);
    chk("b_skip_ready_high", b_rdy, 32'sd1);
    push(1'b1, 16'sd0, 16'sd0);
    chk("b_skipped_no_sym", b_sv, 32'sd0);
    chk("b_skip_ready_still", b_rdy, 32'sd1);
    push(1'b1, 16'sd0, 16'sd0);
    chk("b_post_skip_mid", b_sv, 32'sd0);
    push(1'b1, 16'sd0, 16'sd0);
    chk("b_post_skip_sym", b_sv, 32'sd1);
    chk("b_ted_zero", b_te, 32'sd0);
    chk("b_mu_integ", b_mu, 32'sd7511);
    chk("b_lock_count1", b_lk, 32'sd0);
    push(1'b1, 16'sd0, 16'sd0);
    push(1'b1, 16'sd0, 16'sd0);
    chk("b_locked", b_lk, 32'sd1);
    chk("b_mu_final", b_mu, 32'sd7509);
    chk("b_sym_q_zero", b_sq, 32'sd0);

    // ---- DUT B: replay up to the STUFF cycle, then reset inside it
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    push(1'b1, 16'sd0, 16'sd0);
    push(1'b1, 16'sd0, 16'sd0);
    push(1'b1, 16'sd1000, 16'sd0);
    push(1'b1, 16'sd16384, 16'sd0);
    push(1'b1, 16'sd1100, 16'sd0);
    push(1'b1, 16'sd4376, 16'sd0);
    chk("b_replay_stuff", b_rdy, 32'sd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("b_rs_sym_valid", b_sv, 32'sd0);
    chk("b_rs_sym_i", b_si, 32'sd0);
    chk("b_rs_ready", b_rdy, 32'sd1);
    chk("b_rs_mu", b_mu, 32'sd0);
    chk("b_rs_ted", b_te, 32'sd0);
    chk("b_rs_locked", b_lk, 32'sd0);
    push(1'b1, 16'sd500, 16'sd0);
    chk("b_rs_first_load", b_sv, 32'sd0);
    push(1'b1, 16'sd700, 16'sd0);
    chk("b_rs_sym_valid2", b_sv, 32'sd1);
    chk("b_rs_sym_i2", b_si, 32'sd500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
